// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - SPI initiator turning 10-bit RAM commands into SPI mode-0 frames
//
// Sends {cmd_data[9], cmd_data[9:0]} MSB first on mosi. Opcode 11 (rd-data) adds one dummy
// SCLK period and clocks 8 bits back from miso, returned on rd_data with a rd_valid pulse.
//
// Parameter HALF_PERIOD : clk cycles per sclk half-period (1..255).
// Macro SPI_CMD_MASTER_FIFO_EN : when defined, a 4-entry command FIFO feeds the frame engine.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cmd_data[9:0]       [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload
//   cmd_valid/cmd_ready command handshake
//   rd_data[7:0]        byte from the last rd-data frame, rd_valid one-cycle update pulse
//   sclk, ss_n, mosi    SPI outputs (mode 0), miso SPI input
module spi_cmd_master #(
   parameter int HALF_PERIOD = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       sclk,
   output logic       ss_n,
   output logic       mosi,
   input  logic       miso
);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TURN, READ, HOLD, GAP} state_t;

   localparam logic [8:0] HALF_LAST = 9'(HALF_PERIOD - 1);
   localparam logic [8:0] GAP_LAST  = 9'(2 * HALF_PERIOD - 1);

   state_t      state;
   logic [8:0]  cnt;
   logic [3:0]  bit_cnt;
   logic [10:0] sreg;
   logic [7:0]  rx;
   logic        is_rd;
   logic        half_done;
   logic        gap_done;
   logic        frame_end;
   logic        have_cmd;
   logic        start;
   logic [9:0]  next_cmd;

   assign half_done = (cnt == HALF_LAST);
   assign gap_done  = (cnt == GAP_LAST);
   // HOLD is the trailing low half of the last SCLK period; its end is the end of the frame.
   assign frame_end = (state == HOLD) && half_done;
   assign start     = have_cmd && ((state == IDLE) || ((state == GAP) && gap_done));

`ifdef SPI_CMD_MASTER_FIFO_EN
   logic [9:0] fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic       push;

   assign cmd_ready = (count != 3'd4);
   assign push      = cmd_valid && cmd_ready;
   assign have_cmd  = (count != 3'd0);
   assign next_cmd  = fifo_mem[rd_ptr];

   // The head entry stays queued while its frame runs and is popped when the frame ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (frame_end) rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, push} - {2'b00, frame_end};
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd_data;
   end
`else
   logic ready_q;

   assign cmd_ready = ready_q;
   assign have_cmd  = cmd_valid && ready_q;
   assign next_cmd  = cmd_data;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 9'd0;
         bit_cnt  <= 4'd0;
         sreg     <= 11'd0;
         rx       <= 8'd0;
         is_rd    <= 1'b0;
         sclk     <= 1'b0;
         ss_n     <= 1'b1;
         mosi     <= 1'b0;
         rd_data  <= 8'd0;
         rd_valid <= 1'b0;
`ifndef SPI_CMD_MASTER_FIFO_EN
         ready_q  <= 1'b1;
`endif
      end else begin
         rd_valid <= 1'b0;
         cnt      <= cnt + 9'd1;
         case (state)
            IDLE: cnt <= 9'd0;
            SETUP: begin
               if (half_done) begin
                  cnt   <= 9'd0;
                  sclk  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT, TURN, READ, HOLD: begin
               if (half_done) begin
                  cnt <= 9'd0;
                  if (sclk) begin
                     // Falling edge: present the next bit; sreg runs out to zeros after bit 10.
                     sclk    <= 1'b0;
                     mosi    <= sreg[10];
                     sreg    <= {sreg[9:0], 1'b0};
                     bit_cnt <= bit_cnt + 4'd1;
                     case (state)
                        SHIFT: if (bit_cnt == 4'd10) state <= is_rd ? TURN : HOLD;
                        TURN: begin
                           state   <= READ;
                           bit_cnt <= 4'd0;
                        end
                        READ: if (bit_cnt == 4'd7) state <= HOLD;
                        default: ;
                     endcase
                  end else if (state == HOLD) begin
                     ss_n  <= 1'b1;
                     state <= GAP;
                     if (is_rd) begin
                        rd_data  <= rx;
                        rd_valid <= 1'b1;
                     end
                  end else begin
                     sclk <= 1'b1;
                     if (state == READ) rx <= {rx[6:0], miso};
                  end
               end
            end
            GAP: begin
               if (gap_done) begin
                  state <= IDLE;
                  cnt   <= 9'd0;
`ifndef SPI_CMD_MASTER_FIFO_EN
                  ready_q <= 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase

         if (start) begin
            state   <= SETUP;
            cnt     <= 9'd0;
            bit_cnt <= 4'd0;
            ss_n    <= 1'b0;
            mosi    <= next_cmd[9];
            sreg    <= {next_cmd, 1'b0};
            is_rd   <= &next_cmd[9:8];
`ifndef SPI_CMD_MASTER_FIFO_EN
            ready_q <= 1'b0;
`endif
         end
      end
   end
endmodule
